// File: rtl/exec_unit_wb_pkg.sv
// rtl/exec_unit_wb_pkg.sv - shared opcodes, state encoding and defaults for the execute/writeback stage
package exec_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_AW    = 5;
  localparam int ZERO_REG  = 31;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_ORR = 3'd3;
  localparam logic [2:0] OP_EOR = 3'd4;
  localparam logic [2:0] OP_LSL = 3'd5;
  localparam logic [2:0] OP_LSR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MUL_RUN = 2'd1;
  localparam logic [1:0] ST_WB      = 2'd2;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/exec_unit_wb_if.sv
// rtl/exec_unit_wb_if.sv - issue-side operands/handshake and register-file write port bundle
interface exec_unit_wb_if
  import exec_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
);

  logic             start;
  logic [2:0]       op;
  logic [AW-1:0]    dest;
  logic [WIDTH-1:0] da;
  logic [WIDTH-1:0] db;

  logic             busy;
  logic             done;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output start, op, dest, da, db,
    input  busy, done, wb_en, wb_addr, wb_data, flag_n, flag_z, flag_c, flag_v
  );

  modport slave (
    input  start, op, dest, da, db,
    output busy, done, wb_en, wb_addr, wb_data, flag_n, flag_z, flag_c, flag_v
  );

endinterface

// File: rtl/exec_unit_wb_seq_multiplier.sv
// rtl/exec_unit_wb_seq_multiplier.sv - shift-add multiplier, one multiplier bit per step, low WIDTH bits kept
module seq_multiplier
  import exec_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product_next,
  output logic             count_done
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [6:0]       count;

  // Accumulator value after the step in progress, so the caller can capture
  // the final product on the same edge that performs the last iteration.
  assign product_next = acc + (mplier[0] ? mcand : '0);
  assign count_done   = (count == 7'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (load) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      count  <= '0;
    end else if (step) begin
      acc    <= product_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 7'd1;
    end
  end

endmodule

// File: rtl/exec_unit_wb.sv
// rtl/exec_unit_wb.sv - execute stage: single-cycle ALU or iterative multiply, then one register-file writeback cycle
module exec_unit_wb
  import exec_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int AW       = DEF_AW,
  parameter int ZERO_REG = exec_pkg::ZERO_REG
) (
  input logic          clk,
  input logic          rst,
  exec_unit_wb_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [AW-1:0]    dest_q;
  logic [AW-1:0]    wb_addr_q;
  logic [WIDTH-1:0] wb_data_q;
  flags_t           flags;

  logic             accept;
  logic             is_sub;
  logic             is_arith;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum;
  logic             add_c;
  logic             add_v;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;

  logic             mul_load;
  logic             mul_step;
  logic [WIDTH-1:0] mul_product;
  logic             mul_last;

  assign accept   = (state == ST_IDLE) && bus.start;
  assign is_sub   = (bus.op == OP_SUB);
  assign is_arith = (bus.op == OP_ADD) || is_sub;

  // SUB is a + ~b + 1, so carry out means "no borrow".
  assign b_eff   = is_sub ? ~bus.db : bus.db;
  assign sum_ext = {1'b0, bus.da} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign sum     = sum_ext[WIDTH-1:0];
  assign add_c   = sum_ext[WIDTH];
  assign add_v   = (bus.da[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.da[WIDTH-1]);
  assign shamt   = bus.db[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (bus.op)
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = sum;
      OP_AND:  alu_res = bus.da & bus.db;
      OP_ORR:  alu_res = bus.da | bus.db;
      OP_EOR:  alu_res = bus.da ^ bus.db;
      OP_LSL:  alu_res = bus.da << shamt;
      OP_LSR:  alu_res = bus.da >> shamt;
      default: alu_res = '0;
    endcase
  end

  assign mul_load = accept && (bus.op == OP_MUL);
  assign mul_step = (state == ST_MUL_RUN);

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst          (rst),
    .load         (mul_load),
    .step         (mul_step),
    .a            (bus.da),
    .b            (bus.db),
    .product_next (mul_product),
    .count_done   (mul_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      dest_q    <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      flags     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.op == OP_MUL) begin
              dest_q <= bus.dest;
              state  <= ST_MUL_RUN;
            end else begin
              wb_addr_q <= bus.dest;
              wb_data_q <= alu_res;
              flags.n   <= alu_res[WIDTH-1];
              flags.z   <= (alu_res == '0);
              if (is_arith) begin
                flags.c <= add_c;
                flags.v <= add_v;
              end
              state <= ST_WB;
            end
          end
        end
        ST_MUL_RUN: begin
          // Final iteration: capture the product while the multiplier takes its last step.
          if (mul_last) begin
            wb_addr_q <= dest_q;
            wb_data_q <= mul_product;
            flags.n   <= mul_product[WIDTH-1];
            flags.z   <= (mul_product == '0);
            state     <= ST_WB;
          end
        end
        ST_WB:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = (state != ST_IDLE);
  assign bus.done    = (state == ST_WB);
  assign bus.wb_en   = (state == ST_WB) && (wb_addr_q != AW'(ZERO_REG));
  assign bus.wb_addr = wb_addr_q;
  assign bus.wb_data = wb_data_q;
  assign bus.flag_n  = flags.n;
  assign bus.flag_z  = flags.z;
  assign bus.flag_c  = flags.c;
  assign bus.flag_v  = flags.v;

endmodule

// File: tb/tb_exec_unit_wb.sv
// tb/tb_exec_unit_wb.sv - randomized and directed checks of exec_unit_wb against a cycle-indexed transaction model
module tb_exec_unit_wb;
  import exec_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exec_unit_wb_if #(.WIDTH(64), .AW(5)) bus ();

  exec_unit_wb #(.WIDTH(64), .AW(5), .ZERO_REG(31)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int writes = 0;

  // Model: transactions are tracked by the cycle they were accepted and the cycle they write back.
  int          cyc;
  int          acc_cyc, wb_cyc, free_cyc;
  logic [63:0] pend_res;
  logic [4:0]  pend_dest;
  logic        pend_arith, pend_c, pend_v;
  logic [63:0] exp_data;
  logic [4:0]  exp_addr;
  logic        exp_n, exp_z, exp_c, exp_v;

  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_ORR:  return a | b;
      OP_EOR:  return a ^ b;
      OP_LSL:  return a << b[5:0];
      OP_LSR:  return a >> b[5:0];
      default: return a * b;
    endcase
  endfunction

  task automatic ref_cv(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        output logic c, output logic v);
    logic [64:0] t;
    logic [63:0] r;
    if (op == OP_ADD) begin
      t = {1'b0, a} + {1'b0, b};
      r = a + b;
      c = t[64];
      v = (a[63] == b[63]) && (r[63] != a[63]);
    end else begin
      r = a - b;
      c = (a >= b);
      v = (a[63] != b[63]) && (r[63] != a[63]);
    end
  endtask

  task automatic model_reset();
    acc_cyc  = -10;
    wb_cyc   = -10;
    free_cyc = 0;
    exp_data = '0;
    exp_addr = '0;
    {exp_n, exp_z, exp_c, exp_v} = 4'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    logic e_done;
    e_done = (cyc == wb_cyc);
    chk("busy",    bus.busy,    (cyc > acc_cyc) && (cyc <= wb_cyc));
    chk("done",    bus.done,    e_done);
    chk("wb_en",   bus.wb_en,   e_done && (exp_addr != 5'd31));
    chk("wb_addr", bus.wb_addr, exp_addr);
    chk("wb_data", bus.wb_data, exp_data);
    chk("flag_n",  bus.flag_n,  exp_n);
    chk("flag_z",  bus.flag_z,  exp_z);
    chk("flag_c",  bus.flag_c,  exp_c);
    chk("flag_v",  bus.flag_v,  exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (bus.start && cyc >= free_cyc) begin
        pend_res   = ref_result(bus.op, bus.da, bus.db);
        pend_dest  = bus.dest;
        pend_arith = (bus.op == OP_ADD) || (bus.op == OP_SUB);
        ref_cv(bus.op, bus.da, bus.db, pend_c, pend_v);
        acc_cyc  = cyc;
        wb_cyc   = cyc + ((bus.op == OP_MUL) ? 65 : 1);
        free_cyc = wb_cyc + 1;
      end
      if (cyc + 1 == wb_cyc) begin
        exp_data = pend_res;
        exp_addr = pend_dest;
        exp_n    = pend_res[63];
        exp_z    = (pend_res == 64'd0);
        if (pend_arith) begin
          exp_c = pend_c;
          exp_v = pend_v;
        end
      end
    end
    cyc++;
    @(negedge clk);
    if (bus.wb_en === 1'b1) writes++;
    compare_all();
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] d, input logic [63:0] a, input logic [63:0] b);
    int n;
    bus.start = 1'b1;
    bus.op    = op;
    bus.dest  = d;
    bus.da    = a;
    bus.db    = b;
    tick();
    bus.start = 1'b0;
    bus.da    = {$urandom, $urandom};
    bus.db    = {$urandom, $urandom};
    n = 0;
    while (bus.done !== 1'b1 && n < 80) begin
      tick();
      n++;
    end
    if (bus.done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got done=%b expected 1 within 80 cycles", bus.done);
    end
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return 64'($urandom_range(0, 70));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int w0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = OP_ADD;
    bus.dest  = '0;
    bus.da    = '0;
    bus.db    = '0;
    cyc       = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_done",  bus.done, 0);
    chk("rst_wb_en", bus.wb_en, 0);
    chk("rst_addr",  bus.wb_addr, 0);
    chk("rst_data",  bus.wb_data, 0);
    chk("rst_flags", {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}, 0);
    rst = 1'b0;

    issue(OP_ADD, 5'd3, 64'd5, 64'd7);
    chk("add_data", bus.wb_data, 64'd12);
    chk("add_addr", bus.wb_addr, 64'd3);
    chk("add_en",   bus.wb_en, 1);
    chk("add_nzcv", {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}, 4'b0000);
    tick();
    chk("add_idle", bus.busy, 0);

    issue(OP_SUB, 5'd4, 64'd0, 64'd1);
    chk("sub_data", bus.wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sub_nzc",  {bus.flag_n, bus.flag_z, bus.flag_c}, 3'b100);
    tick();
    issue(OP_SUB, 5'd5, 64'h55, 64'h55);
    chk("sub0_data", bus.wb_data, 64'd0);
    chk("sub0_zc",   {bus.flag_z, bus.flag_c}, 2'b11);
    tick();

    issue(OP_ADD, 5'd6, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    chk("ovf_data", bus.wb_data, 64'h8000_0000_0000_0000);
    chk("ovf_nvc",  {bus.flag_n, bus.flag_v, bus.flag_c}, 3'b110);
    tick();
    issue(OP_AND, 5'd7, 64'hF0, 64'h3C);
    chk("and_data", bus.wb_data, 64'h30);
    chk("and_cv",   {bus.flag_c, bus.flag_v}, 2'b01);
    tick();

    // Multiply with ignored start pulses mid-run and in the WB cycle.
    w0        = writes;
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.dest  = 5'd9;
    bus.da    = 64'h1_0000_0001;
    bus.db    = 64'd3;
    tick();
    for (int k = 1; k <= 65; k++) begin
      chk("mul_busy", bus.busy, 1);
      if (k == 65) begin
        chk("mul_done", bus.done, 1);
        chk("mul_data", bus.wb_data, 64'h3_0000_0003);
        chk("mul_addr", bus.wb_addr, 64'd9);
      end
      bus.start = (k == 10) || (k == 65);
      bus.op    = OP_ADD;
      bus.dest  = 5'd2;
      bus.da    = {$urandom, $urandom};
      bus.db    = {$urandom, $urandom};
      tick();
    end
    bus.start = 1'b0;
    chk("mul_after_busy", bus.busy, 0);
    chk("mul_one_write",  64'(writes - w0), 64'd1);

    w0 = writes;
    issue(OP_ADD, 5'd31, 64'd1, 64'd1);
    chk("zr_done", bus.done, 1);
    chk("zr_en",   bus.wb_en, 0);
    chk("zr_z",    bus.flag_z, 0);
    tick();
    chk("zr_no_write", 64'(writes - w0), 64'd0);

    // Asynchronous reset in the middle of a multiply.
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.dest  = 5'd8;
    bus.da    = 64'd1234;
    bus.db    = 64'd99;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k < 30; k++) tick();
    w0 = writes;
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",  bus.busy, 0);
    chk("arst_done",  bus.done, 0);
    chk("arst_en",    bus.wb_en, 0);
    chk("arst_flags", {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}, 0);
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 40; k++) tick();
    chk("arst_no_write", 64'(writes - w0), 64'd0);
    issue(OP_ADD, 5'd4, 64'd2, 64'd3);
    chk("post_rst_data", bus.wb_data, 64'd5);
    chk("post_rst_en",   bus.wb_en, 1);
    tick();

    // Randomized traffic: operands and start keep changing while operations are in flight.
    for (int i = 0; i < 1500; i++) begin
      bus.start = ($urandom_range(0, 2) == 0);
      bus.op    = ($urandom_range(0, 7) == 0) ? OP_MUL : 3'($urandom_range(0, 6));
      bus.dest  = 5'($urandom_range(0, 31));
      bus.da    = pick();
      bus.db    = pick();
      tick();
    end
    bus.start = 1'b0;
    for (int k = 0; k < 70; k++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
